// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- writeback stage of the 5-stage MIPS pipeline.
//
// Latches the memory-stage bus, commits register-file writes, hosts the CP0
// registers (Status, Cause, EPC, Count, Compare, BadVAddr), resolves
// exceptions and eret, and drives the debug trace port.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   ms_to_ws_valid      memory stage holds a valid instruction
//   ms_to_ws_bus        {bd, rt_value, cp0_dest, eret, mtc0, mfc0, excp_valid,
//                        excode, gr_we, dest, final_result, pc}
//   ws_allowin          writeback stage can accept a new instruction
//   ws_to_rf_bus        register-file write port {we, waddr, wdata}
//   ws_to_ds_fw_bus     forwarding copy of the register-file write port
//   ext_int_in          level-sensitive hardware interrupt lines
//   cp0_general_bus     {eret_flush, int_pending, status_EXL, status_IE}
//   excp_flush          exception commits this cycle
//   cp0_epc             current EPC (eret target)
//   debug_wb_*          commit trace: pc, byte write enables, wnum, wdata
// ---------------------------------------------------------------------------
module wb_stage #(
   parameter int MS_TO_WS_BUS_WD = 120,
   parameter int WS_TO_RF_BUS_WD = 38
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ms_to_ws_valid,
   input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic                       ws_allowin,
   output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
   output logic [WS_TO_RF_BUS_WD-1:0] ws_to_ds_fw_bus,
   input  logic [5:0]                 ext_int_in,
   output logic [3:0]                 cp0_general_bus,
   output logic                       excp_flush,
   output logic [31:0]                cp0_epc,
   output logic [31:0]                debug_wb_pc,
   output logic [3:0]                 debug_wb_rf_wen,
   output logic [4:0]                 debug_wb_rf_wnum,
   output logic [31:0]                debug_wb_rf_wdata
);

   // CP0 addresses as {rd[4:0], sel[2:0]}
   localparam logic [7:0] CP0_BADVADDR = 8'h40;   // {8,0}
   localparam logic [7:0] CP0_COUNT    = 8'h48;   // {9,0}
   localparam logic [7:0] CP0_COMPARE  = 8'h58;   // {11,0}
   localparam logic [7:0] CP0_STATUS   = 8'h60;   // {12,0}
   localparam logic [7:0] CP0_CAUSE    = 8'h68;   // {13,0}
   localparam logic [7:0] CP0_EPC      = 8'h70;   // {14,0}

   localparam logic WS_READY_GO = 1'b1;

   // Pipeline registers
   logic                       ws_valid_q, ws_valid_d;
   logic [MS_TO_WS_BUS_WD-1:0] ms_bus_q, ms_bus_d;

   // CP0 state
   logic [31:0] badvaddr_q, badvaddr_d;
   logic [31:0] count_q,    count_d;
   logic [31:0] compare_q,  compare_d;
   logic        tick_q,     tick_d;
   logic [7:0]  im_q,       im_d;
   logic        exl_q,      exl_d;
   logic        ie_q,       ie_d;
   logic        cause_bd_q, cause_bd_d;
   logic        ti_q,       ti_d;
   logic [5:0]  ip_hw_q,    ip_hw_d;
   logic [1:0]  ip_sw_q,    ip_sw_d;
   logic [4:0]  exccode_q,  exccode_d;
   logic [31:0] epc_q,      epc_d;

   // Decoded fields of the latched instruction
   logic [31:0] pc_s;
   logic [31:0] result_s;
   logic [4:0]  dest_s;
   logic        gr_we_s;
   logic [4:0]  excode_s;
   logic        excp_valid_s;
   logic        mfc0_s;
   logic        mtc0_s;
   logic        eret_s;
   logic [7:0]  cp0_dest_s;
   logic [31:0] rt_value_s;
   logic        bd_s;

   logic        ws_act_s;
   logic        excp_flush_s;
   logic        eret_flush_s;
   logic        mtc0_we_s;
   logic        wr_count_s, wr_compare_s, wr_status_s, wr_cause_s, wr_epc_s;
   logic [31:0] status_rd_s;
   logic [31:0] cause_rd_s;
   logic [31:0] cp0_rdata_s;
   logic        rf_we_s;
   logic [31:0] rf_wdata_s;
   logic        int_pending_s;

   assign pc_s         = ms_bus_q[31:0];
   assign result_s     = ms_bus_q[63:32];
   assign dest_s       = ms_bus_q[68:64];
   assign gr_we_s      = ms_bus_q[69];
   assign excode_s     = ms_bus_q[74:70];
   assign excp_valid_s = ms_bus_q[75];
   assign mfc0_s       = ms_bus_q[76];
   assign mtc0_s       = ms_bus_q[77];
   assign eret_s       = ms_bus_q[78];
   assign cp0_dest_s   = ms_bus_q[86:79];
   assign rt_value_s   = ms_bus_q[118:87];
   assign bd_s         = ms_bus_q[119];

   // Gating with reset keeps every commit-side output at 0 while reset is held,
   // including the first cycle before the synchronous reset has taken effect.
   assign ws_act_s     = ws_valid_q & ~reset;
   assign excp_flush_s = ws_act_s & excp_valid_s;
   assign eret_flush_s = ws_act_s & eret_s & ~excp_valid_s;
   assign mtc0_we_s    = ws_act_s & mtc0_s & ~excp_valid_s;
   assign ws_allowin   = ~ws_valid_q | WS_READY_GO;

   // Handshake: next valid bit and bus latch
   always_comb begin
      ws_valid_d = ws_valid_q;
      ms_bus_d   = ms_bus_q;
      if (excp_flush_s | eret_flush_s) begin
         ws_valid_d = 1'b0;
      end else if (ws_allowin) begin
         ws_valid_d = ms_to_ws_valid;
      end else begin
         ws_valid_d = ws_valid_q;
      end
      if (ms_to_ws_valid & ws_allowin) begin
         ms_bus_d = ms_to_ws_bus;
      end else begin
         ms_bus_d = ms_bus_q;
      end
   end

   // Decode mtc0 target into per-register write strobes
   always_comb begin
      wr_count_s   = 1'b0;
      wr_compare_s = 1'b0;
      wr_status_s  = 1'b0;
      wr_cause_s   = 1'b0;
      wr_epc_s     = 1'b0;
      case (cp0_dest_s)
         CP0_COUNT:   wr_count_s   = mtc0_we_s;
         CP0_COMPARE: wr_compare_s = mtc0_we_s;
         CP0_STATUS:  wr_status_s  = mtc0_we_s;
         CP0_CAUSE:   wr_cause_s   = mtc0_we_s;
         CP0_EPC:     wr_epc_s     = mtc0_we_s;
         default:     wr_count_s   = 1'b0;
      endcase
   end

   // Timer: Count, Compare, tick toggle and the TI flag
   always_comb begin
      tick_d    = ~tick_q;
      count_d   = count_q;
      compare_d = compare_q;
      ti_d      = ti_q;
      if (wr_count_s) begin
         count_d = rt_value_s;
      end else if (tick_q) begin
         count_d = count_q + 32'd1;
      end else begin
         count_d = count_q;
      end
      if (wr_compare_s) begin
         compare_d = rt_value_s;
      end else begin
         compare_d = compare_q;
      end
      // A Compare write beats a same-cycle match
      if (wr_compare_s) begin
         ti_d = 1'b0;
      end else if (count_q == compare_q) begin
         ti_d = 1'b1;
      end else begin
         ti_d = ti_q;
      end
   end

   // Status, Cause, EPC and BadVAddr updates from exceptions, eret and mtc0
   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      cause_bd_d = cause_bd_q;
      exccode_d  = exccode_q;
      epc_d      = epc_q;
      badvaddr_d = badvaddr_q;
      ip_hw_d    = {ext_int_in[5] | ti_q, ext_int_in[4:0]};
      ip_sw_d    = ip_sw_q;

      if (excp_flush_s) begin
         exl_d     = 1'b1;
         exccode_d = excode_s;
         // A nested exception keeps the original return point
         if (!exl_q) begin
            epc_d      = bd_s ? (pc_s - 32'd4) : pc_s;
            cause_bd_d = bd_s;
         end else begin
            epc_d      = epc_q;
            cause_bd_d = cause_bd_q;
         end
         if ((excode_s == 5'h04) || (excode_s == 5'h05)) begin
            badvaddr_d = result_s;
         end else begin
            badvaddr_d = badvaddr_q;
         end
      end else if (eret_flush_s) begin
         exl_d = 1'b0;
      end else if (wr_status_s) begin
         im_d  = rt_value_s[15:8];
         exl_d = rt_value_s[1];
         ie_d  = rt_value_s[0];
      end else begin
         exl_d = exl_q;
      end

      if (wr_cause_s) begin
         ip_sw_d = rt_value_s[9:8];
      end else begin
         ip_sw_d = ip_sw_q;
      end

      if (wr_epc_s) begin
         epc_d = rt_value_s;
      end else begin
         cause_bd_d = cause_bd_d;
      end
   end

   // All state registers, synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         ws_valid_q <= 1'b0;
         ms_bus_q   <= '0;
         badvaddr_q <= 32'd0;
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         tick_q     <= 1'b0;
         im_q       <= 8'd0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         cause_bd_q <= 1'b0;
         ti_q       <= 1'b0;
         ip_hw_q    <= 6'd0;
         ip_sw_q    <= 2'd0;
         exccode_q  <= 5'd0;
         epc_q      <= 32'd0;
      end else begin
         ws_valid_q <= ws_valid_d;
         ms_bus_q   <= ms_bus_d;
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         tick_q     <= tick_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         cause_bd_q <= cause_bd_d;
         ti_q       <= ti_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
         epc_q      <= epc_d;
      end
   end

   // Architectural views; BEV is hard-wired to 1
   assign status_rd_s = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause_rd_s  = {cause_bd_q, ti_q, 14'd0, ip_hw_q, ip_sw_q, 1'b0, exccode_q, 2'd0};

   // mfc0 read mux; unmapped addresses read 0
   always_comb begin
      cp0_rdata_s = 32'd0;
      case (cp0_dest_s)
         CP0_BADVADDR: cp0_rdata_s = badvaddr_q;
         CP0_COUNT:    cp0_rdata_s = count_q;
         CP0_COMPARE:  cp0_rdata_s = compare_q;
         CP0_STATUS:   cp0_rdata_s = status_rd_s;
         CP0_CAUSE:    cp0_rdata_s = cause_rd_s;
         CP0_EPC:      cp0_rdata_s = epc_q;
         default:      cp0_rdata_s = 32'd0;
      endcase
   end

   assign rf_we_s       = ws_act_s & gr_we_s & ~excp_valid_s;
   assign rf_wdata_s    = mfc0_s ? cp0_rdata_s : result_s;
   assign int_pending_s = (|({ip_hw_q, ip_sw_q} & im_q)) & ie_q & ~exl_q & ~reset;

   assign ws_to_rf_bus    = {rf_we_s, dest_s, rf_wdata_s};
   assign ws_to_ds_fw_bus = {rf_we_s, dest_s, rf_wdata_s};
   assign excp_flush      = excp_flush_s;
   assign cp0_general_bus = {eret_flush_s, int_pending_s, exl_q & ~reset, ie_q & ~reset};
   assign cp0_epc         = reset ? 32'd0 : epc_q;

   assign debug_wb_pc       = pc_s;
   assign debug_wb_rf_wen   = {4{rf_we_s}};
   assign debug_wb_rf_wnum  = dest_s;
   assign debug_wb_rf_wdata = rf_wdata_s;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (writeback) stage of the 5-stage MIPS pipeline. Consumes the memory-stage bus and commits register-file writes.
- Hosts the CP0 registers: Status, Cause, EPC, Count, Compare, BadVAddr.
- Resolves exceptions and eret, raising pipeline flushes and the CP0 status bus used by earlier stages.
- Drives the debug trace port for commit comparison.

Parameters:
- MS_TO_WS_BUS_WD, 120, width of the memory-to-writeback bus.
- WS_TO_RF_BUS_WD, 38, width of the register-file write bus {we, waddr[4:0], wdata[31:0]}.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ms_to_ws_valid  in  1  memory stage holds a valid instruction
- ms_to_ws_bus  in  120  [31:0] pc, [63:32] final_result, [68:64] dest, [69] gr_we, [74:70] excode, [75] excp_valid, [76] mfc0, [77] mtc0, [78] eret, [86:79] cp0_dest {rd[4:0], sel[2:0]}, [118:87] rt_value, [119] bd
- ws_allowin  out  1  writeback stage can accept
- ws_to_rf_bus  out  38  register-file write port
- ws_to_ds_fw_bus  out  38  forward bus {we, dest, wdata}, same timing as the RF write
- ext_int_in  in  6  hardware interrupt lines, level-sensitive
- cp0_general_bus  out  4  {eret_flush, int_pending, status_EXL, status_IE}
- excp_flush  out  1  exception commit this cycle
- cp0_epc  out  32  current EPC, eret target
- debug_wb_pc  out  32  committed PC
- debug_wb_rf_wen  out  4  byte write enables, all four equal to rf we
- debug_wb_rf_wnum  out  5  committed destination register
- debug_wb_rf_wdata  out  32  committed write data

Behaviour:
- Handshake:
  - ws_ready_go = 1; ws_allowin = !ws_valid | ws_ready_go.
  - Bus is latched when ms_to_ws_valid & ws_allowin.
  - ws_valid <= 0 on reset or when excp_flush | eret_flush; otherwise ws_valid <= ms_to_ws_valid whenever ws_allowin.
- Commit:
  - excp_flush = ws_valid & excp_valid.
  - eret_flush = ws_valid & eret & !excp_valid. Both are combinational, same cycle.
  - rf we = ws_valid & gr_we & !excp_valid.
  - wdata = mfc0 ? cp0_rdata : final_result.
  - mtc0 write enable = ws_valid & mtc0 & !excp_valid; data = rt_value.
- CP0 read/write map, selected by cp0_dest. Unmapped addresses read 0 and ignore writes.
  - BadVAddr {8,0}: read-only. Loaded with final_result on exception commit when excode is 0x04 or 0x05.
  - Count {9,0}: read/write. Increments by 1 every second cycle via an internal tick toggle (tick reset 0). Wraps at 0xFFFFFFFF→0. An mtc0 write overrides the increment that cycle.
  - Compare {11,0}: read/write. A write clears Cause.TI.
  - Status {12,0}: reset 0x00400000. BEV [22] is read-only 1. IM [15:8] is read/write. EXL [1] is read/write. IE [0] is read/write. All other bits read 0.
  - Cause {13,0}:
    - BD [31] and TI [30] are hardware-only.
    - IP[7:2] is sampled every cycle as {ext_int_in[5] | TI, ext_int_in[4:0]}.
    - IP[1:0] is read/write.
    - ExcCode [6:2] is hardware-only.
    - Reset value 0.
  - EPC {14,0}: read/write, reset 0.
- TI:
  - Set when Count == Compare. Cleared by a Compare write; the write wins on the same cycle.
  - Held otherwise; reset 0.
- Exception commit:
  - ExcCode <= excode; Status.EXL <= 1.
  - If EXL was 0: EPC <= bd ? pc-4 : pc, and Cause.BD <= bd.
  - If EXL was already 1: EPC and BD are unchanged.
  - Exception writes take priority over a same-cycle mtc0, which is suppressed anyway.
- eret: Status.EXL <= 0.
- int_pending = |(Cause.IP & Status.IM) & IE & !EXL. It is combinational, and upstream tags the interrupt.
- Outputs during reset:
  - rf we = 0, debug_wb_rf_wen = 0.
  - excp_flush = 0, eret_flush = 0.
  - cp0_epc = 0.
  - cp0_general_bus = 4'b0000.
- debug_wb_pc = pc of the latched instruction, whether valid or not. debug_wb_rf_wnum = dest.

Test Plan:
- Reset, then ALU result: pc=0xBFC00000, gr_we=1, dest=5, result=0x1234 → rf bus {1, 5, 0x00001234}; debug_wb_rf_wen=4'hF one cycle later.
- mtc0 0x0000FF01 to Status {12,0}, then mfc0 → rd receives 0x0040FF01; cp0_general_bus IE=1.
- Exception, excode=0x04, bd=1, pc=0x80001004, final_result=0x80002003 → excp_flush=1, rf we=0; next cycle EPC=0x80001000, Cause=0x80000010, BadVAddr=0x80002003, EXL=1.
- eret with EPC=0x80001000 → eret_flush=1 same cycle, cp0_epc=0x80001000; EXL=0 next cycle; the following instruction is squashed.
- Compare=3, Count=0, IM[7]=1, IE=1 → Count reaches 3 after 6 cycles; TI=1; int_pending=1 the next cycle. Compare write 3 → TI=0.
- Nested exception with EXL=1, excode 0x0A → EPC unchanged, ExcCode=0x0A.
